// File: rtl/operand_src_ctrl_if.sv
// ID->EX operand-source interface: ID-stage instruction in, ID/EX control and field registers out.
interface operand_src_ctrl_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        flush;
  logic        id_stall;
  logic        ex_valid;
  logic        ex_alusrc;
  logic        ex_ldur_stur;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_illegal;
  logic [11:0] ex_imm12;
  logic [8:0]  ex_imm9;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rn;
  logic [4:0]  ex_rm;

  modport master (
    output id_valid, id_instr, flush,
    input  id_stall, ex_valid, ex_alusrc, ex_ldur_stur, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_illegal, ex_imm12, ex_imm9, ex_rd, ex_rn, ex_rm
  );

  modport slave (
    input  id_valid, id_instr, flush,
    output id_stall, ex_valid, ex_alusrc, ex_ldur_stur, ex_mem_read, ex_mem_write,
           ex_reg_write, ex_illegal, ex_imm12, ex_imm9, ex_rd, ex_rn, ex_rm
  );
endinterface

// File: rtl/operand_src_ctrl.sv
// ID->EX operand-source controller: decodes ALUsrc/LDUR_STUR controls, registers ID/EX,
// and stalls IF/ID with EX bubbles on load-use hazards.
module operand_src_ctrl #(
  parameter int         STALL_CYCLES = 1,
  parameter logic [4:0] XZR_REG      = 5'd31
) (
  input logic              clk,
  input logic              reset,
  operand_src_ctrl_if.slave bus
);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic        valid;
    logic        alusrc;
    logic        ldurStur;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        illegal;
    logic [11:0] imm12;
    logic [8:0]  imm9;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
  } exRegs_t;

  localparam logic [1:0] CNT_INIT = 2'(STALL_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [1:0]  r_cnt;
  logic [1:0]  w_nextCnt;
  exRegs_t     r_ex;
  exRegs_t     w_next;
  exRegs_t     w_dec;
  logic        w_legal;
  logic        w_readsRn;
  logic        w_readsRm;
  logic        w_readsRt;
  logic        w_hazard;
  logic        w_stall;
  logic [10:0] w_op11;
  logic [4:0]  w_rd;
  logic [4:0]  w_rn;
  logic [4:0]  w_rm;

  assign w_op11 = bus.id_instr[31:21];
  assign w_rd   = bus.id_instr[4:0];
  assign w_rn   = bus.id_instr[9:5];
  assign w_rm   = bus.id_instr[20:16];

  // Instruction decode; also records which source registers the ID instruction reads
  always_comb begin
    w_dec     = '0;
    w_legal   = 1'b0;
    w_readsRn = 1'b0;
    w_readsRm = 1'b0;
    w_readsRt = 1'b0;
    if (w_op11 == 11'h7C2) begin
      w_legal          = 1'b1;
      w_dec.alusrc     = 1'b1;
      w_dec.ldurStur   = 1'b1;
      w_dec.memRead    = 1'b1;
      w_dec.regWrite   = 1'b1;
      w_readsRn        = 1'b1;
    end else if (w_op11 == 11'h7C0) begin
      w_legal          = 1'b1;
      w_dec.alusrc     = 1'b1;
      w_dec.ldurStur   = 1'b1;
      w_dec.memWrite   = 1'b1;
      w_readsRn        = 1'b1;
      w_readsRt        = 1'b1;
    end else if (bus.id_instr[31:22] == 10'h244) begin
      w_legal          = 1'b1;
      w_dec.alusrc     = 1'b1;
      w_dec.regWrite   = 1'b1;
      w_readsRn        = 1'b1;
    end else if ((w_op11 == 11'h458) || (w_op11 == 11'h658)) begin
      w_legal          = 1'b1;
      w_dec.regWrite   = 1'b1;
      w_readsRn        = 1'b1;
      w_readsRm        = 1'b1;
    end
    if (w_legal) begin
      w_dec.valid = 1'b1;
      w_dec.imm12 = bus.id_instr[21:10];
      w_dec.imm9  = bus.id_instr[20:12];
      w_dec.rd    = w_rd;
      w_dec.rn    = w_rn;
      w_dec.rm    = w_rm;
    end
  end

  // A bubble in EX has valid=0, so it can never raise a hazard
  assign w_hazard = r_ex.valid & r_ex.memRead & bus.id_valid & (r_ex.rd != XZR_REG) &
                    ((w_readsRn & (w_rn == r_ex.rd)) |
                     (w_readsRm & (w_rm == r_ex.rd)) |
                     (w_readsRt & (w_rd == r_ex.rd)));

  // Flush beats everything; the hazard cycle itself counts as the first stall cycle
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_next      = '0;
    w_stall     = 1'b0;
    if (bus.flush) begin
      w_nextState = RUN;
      w_nextCnt   = 2'd0;
    end else if (r_state == STALL) begin
      w_stall = 1'b1;
      if (r_cnt <= 2'd1) begin
        w_nextState = RUN;
        w_nextCnt   = 2'd0;
      end else begin
        w_nextCnt = r_cnt - 2'd1;
      end
    end else if (w_hazard) begin
      w_stall   = 1'b1;
      w_nextCnt = CNT_INIT;
      if (STALL_CYCLES > 1) begin
        w_nextState = STALL;
      end
    end else if (bus.id_valid) begin
      if (w_legal) begin
        w_next = w_dec;
      end else begin
        w_next.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
      r_ex    <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_ex    <= w_next;
    end
  end

  assign bus.id_stall     = w_stall;
  assign bus.ex_valid     = r_ex.valid;
  assign bus.ex_alusrc    = r_ex.alusrc;
  assign bus.ex_ldur_stur = r_ex.ldurStur;
  assign bus.ex_mem_read  = r_ex.memRead;
  assign bus.ex_mem_write = r_ex.memWrite;
  assign bus.ex_reg_write = r_ex.regWrite;
  assign bus.ex_illegal   = r_ex.illegal;
  assign bus.ex_imm12     = r_ex.imm12;
  assign bus.ex_imm9      = r_ex.imm9;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.ex_rn        = r_ex.rn;
  assign bus.ex_rm        = r_ex.rm;

endmodule

// File: tb/tb_operand_src_ctrl.sv
// Directed testbench for operand_src_ctrl; three instances (1, 2 and 3 stall cycles)
// share the same stimulus and each is checked where its stall depth matters.
module tb_operand_src_ctrl;

  logic clk;
  logic reset;
  int   nChecks;
  int   nPass;

  operand_src_ctrl_if bus1 ();
  operand_src_ctrl_if bus2 ();
  operand_src_ctrl_if bus3 ();

  operand_src_ctrl #(.STALL_CYCLES(1), .XZR_REG(5'd31)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  operand_src_ctrl #(.STALL_CYCLES(2), .XZR_REG(5'd31)) u2 (.clk(clk), .reset(reset), .bus(bus2));
  operand_src_ctrl #(.STALL_CYCLES(3), .XZR_REG(5'd31)) u3 (.clk(clk), .reset(reset), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encD(input logic [10:0] op, input logic [8:0] imm9,
                                      input logic [4:0] rn, input logic [4:0] rt);
    return {op, imm9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm12, input logic [4:0] rn,
                                      input logic [4:0] rd);
    return {10'h244, imm12, rn, rd};
  endfunction

  function automatic logic [31:0] encR(input logic [10:0] op, input logic [4:0] rm,
                                      input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic fl);
    bus1.id_valid = valid; bus1.id_instr = instr; bus1.flush = fl;
    bus2.id_valid = valid; bus2.id_instr = instr; bus2.flush = fl;
    bus3.id_valid = valid; bus3.id_instr = instr; bus3.flush = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (n) tick();
  endtask

  logic [31:0] iAddi, iStur, iAdd, iLdur9, iAddDep, iLdur31, iAdd31, iAddiNo, iSturRt;

  initial begin
    nChecks = 0;
    nPass   = 0;
    iAddi   = encI(12'd5, 5'd2, 5'd1);
    iStur   = encD(11'h7C0, 9'h1FE, 5'd4, 5'd3);
    iAdd    = encR(11'h458, 5'd7, 5'd6, 5'd5);
    iLdur9  = encD(11'h7C2, 9'd0, 5'd2, 5'd9);
    iAddDep = encR(11'h458, 5'd3, 5'd9, 5'd1);
    iLdur31 = encD(11'h7C2, 9'd0, 5'd2, 5'd31);
    iAdd31  = encR(11'h458, 5'd31, 5'd31, 5'd1);
    iAddiNo = encI(12'd1, 5'd8, 5'd1);
    iSturRt = encD(11'h7C0, 9'd0, 5'd2, 5'd9);

    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (2) tick();
    reset = 1'b0;

    // Asynchronous reset while an ADD sits in ID and EX holds a valid ADDI
    applyStimulus(1'b1, iAddi, 1'b0);
    tick();
    applyStimulus(1'b1, iAdd, 1'b0);
    checkOutput("pre_reset_valid", bus1.ex_valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_valid", bus1.ex_valid, 0);
    checkOutput("rst_alusrc", bus1.ex_alusrc, 0);
    checkOutput("rst_regwrite", bus1.ex_reg_write, 0);
    checkOutput("rst_imm12", bus1.ex_imm12, 0);
    checkOutput("rst_rm", bus1.ex_rm, 0);
    checkOutput("rst_stall", bus1.id_stall, 0);
    tick();
    reset = 1'b0;
    idle(1);

    // Streaming ADDI, STUR, ADD
    applyStimulus(1'b1, iAddi, 1'b0);
    checkOutput("str_stall0", bus1.id_stall, 0);
    tick();
    applyStimulus(1'b1, iStur, 1'b0);
    checkOutput("addi_valid", bus1.ex_valid, 1);
    checkOutput("addi_alusrc", bus1.ex_alusrc, 1);
    checkOutput("addi_ldurstur", bus1.ex_ldur_stur, 0);
    checkOutput("addi_imm12", bus1.ex_imm12, 12'h005);
    checkOutput("str_stall1", bus1.id_stall, 0);
    tick();
    applyStimulus(1'b1, iAdd, 1'b0);
    checkOutput("stur_alusrc", bus1.ex_alusrc, 1);
    checkOutput("stur_ldurstur", bus1.ex_ldur_stur, 1);
    checkOutput("stur_imm9", bus1.ex_imm9, 9'h1FE);
    checkOutput("stur_memwrite", bus1.ex_mem_write, 1);
    checkOutput("stur_regwrite", bus1.ex_reg_write, 0);
    checkOutput("str_stall2", bus1.id_stall, 0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("add_alusrc", bus1.ex_alusrc, 0);
    checkOutput("add_rm", bus1.ex_rm, 7);
    checkOutput("add_rd", bus1.ex_rd, 5);
    tick();
    idle(2);

    // Load-use: u1 stalls one cycle, u2 stalls two
    applyStimulus(1'b1, iLdur9, 1'b0);
    tick();
    applyStimulus(1'b1, iAddDep, 1'b0);
    checkOutput("lu_memread", bus1.ex_mem_read, 1);
    checkOutput("lu1_stall_a", bus1.id_stall, 1);
    checkOutput("lu2_stall_a", bus2.id_stall, 1);
    tick();
    checkOutput("lu1_stall_b", bus1.id_stall, 0);
    checkOutput("lu1_bubble", bus1.ex_valid, 0);
    checkOutput("lu2_stall_b", bus2.id_stall, 1);
    checkOutput("lu2_bubble1", bus2.ex_valid, 0);
    tick();
    checkOutput("lu1_add_valid", bus1.ex_valid, 1);
    checkOutput("lu1_add_rn", bus1.ex_rn, 9);
    checkOutput("lu2_stall_c", bus2.id_stall, 0);
    checkOutput("lu2_bubble2", bus2.ex_valid, 0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("lu2_add_valid", bus2.ex_valid, 1);
    checkOutput("lu2_add_rm", bus2.ex_rm, 3);
    idle(4);

    // XZR and no-dependency cases, then an Rt match
    applyStimulus(1'b1, iLdur31, 1'b0);
    tick();
    applyStimulus(1'b1, iAdd31, 1'b0);
    checkOutput("xzr_memread", bus1.ex_mem_read, 1);
    checkOutput("xzr_rd", bus1.ex_rd, 31);
    checkOutput("xzr_stall", bus1.id_stall, 0);
    tick();
    applyStimulus(1'b1, iLdur9, 1'b0);
    tick();
    applyStimulus(1'b1, iAddiNo, 1'b0);
    checkOutput("nodep_stall", bus1.id_stall, 0);
    tick();
    applyStimulus(1'b1, iLdur9, 1'b0);
    tick();
    applyStimulus(1'b1, iSturRt, 1'b0);
    checkOutput("rt_stall", bus1.id_stall, 1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("rt_bubble", bus1.ex_valid, 0);
    idle(4);

    // Flush in the second stall cycle of the 3-cycle instance
    applyStimulus(1'b1, iLdur9, 1'b0);
    tick();
    applyStimulus(1'b1, iAddDep, 1'b0);
    checkOutput("fl_stall_a", bus3.id_stall, 1);
    tick();
    checkOutput("fl_stall_b_noflush", bus3.id_stall, 1);
    applyStimulus(1'b1, iAddDep, 1'b1);
    checkOutput("fl_stall_forced0", bus3.id_stall, 0);
    checkOutput("fl_bubble1", bus3.ex_valid, 0);
    tick();
    applyStimulus(1'b1, iAddDep, 1'b0);
    checkOutput("fl_bubble2", bus3.ex_valid, 0);
    checkOutput("fl_illegal", bus3.ex_illegal, 0);
    checkOutput("fl_run_stall", bus3.id_stall, 0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("fl_add_valid", bus3.ex_valid, 1);
    checkOutput("fl_add_rm", bus3.ex_rm, 3);
    checkOutput("fl_after_stall", bus3.id_stall, 0);
    idle(4);

    // Illegal opcode becomes a flagged bubble, then decode resumes
    applyStimulus(1'b1, 32'h0000_0000, 1'b0);
    tick();
    applyStimulus(1'b1, iAddi, 1'b0);
    checkOutput("ill_flag", bus1.ex_illegal, 1);
    checkOutput("ill_valid", bus1.ex_valid, 0);
    checkOutput("ill_alusrc", bus1.ex_alusrc, 0);
    checkOutput("ill_regwrite", bus1.ex_reg_write, 0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("post_ill_flag", bus1.ex_illegal, 0);
    checkOutput("post_ill_valid", bus1.ex_valid, 1);
    checkOutput("post_ill_alusrc", bus1.ex_alusrc, 1);
    checkOutput("post_ill_imm12", bus1.ex_imm12, 12'h005);
    idle(2);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
